// File: rtl/fetch_unit.sv
// Decoupled instruction prefetcher: credit-limited fixed-latency imem fetch feeding
// a prefetch queue that drains to decode over valid/ready; redirect squashes everything.
module fetch_unit #(
   parameter int unsigned           ADDR_WIDTH  = 16,
   parameter int unsigned           INST_WIDTH  = 32,
   parameter int unsigned           QUEUE_DEPTH = 4,
   parameter int unsigned           MEM_LATENCY = 1,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic                           imem_req,
   output logic [ADDR_WIDTH-1:0]          imem_addr,
   input  logic [INST_WIDTH-1:0]          imem_rdata,
   input  logic                           redirect,
   input  logic [ADDR_WIDTH-1:0]          redirect_pc,
   output logic                           inst_valid,
   input  logic                           inst_ready,
   output logic [INST_WIDTH-1:0]          inst,
   output logic [ADDR_WIDTH-1:0]          inst_pc,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned INF_W = $clog2(MEM_LATENCY + 1);
   localparam int unsigned OCC_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [ADDR_WIDTH-1:0] pipe_pc_q [MEM_LATENCY];
   logic [ADDR_WIDTH-1:0] pipe_pc_d [MEM_LATENCY];
   logic [INST_WIDTH-1:0] q_inst_q [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] q_pc_q   [QUEUE_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [INF_W-1:0]      inflight;
   logic [OCC_W-1:0]      occupancy;
   logic                  issue, enq, enq_ok, deq, wr_en;

   // Outstanding requests: every valid pipe stage holds a queue credit.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
         inflight = inflight + INF_W'(pipe_vld_q[i]);
      end
   end

   assign occupancy = OCC_W'(count_q) + OCC_W'(inflight);
   assign issue     = !reset && !redirect && (occupancy < OCC_W'(QUEUE_DEPTH));
   assign enq       = pipe_vld_q[MEM_LATENCY-1];
   assign enq_ok    = enq && !redirect;
   assign wr_en     = enq_ok && !reset;
   assign deq       = inst_valid && inst_ready;

   assign imem_req    = issue;
   assign imem_addr   = fetch_pc_q;
   assign inst_valid  = !reset && (count_q != '0);
   assign inst        = q_inst_q[head_q];
   assign inst_pc     = q_pc_q[head_q];
   assign queue_count = reset ? '0 : count_q;

   // Next-state for fetch PC, in-flight pipe and queue pointers.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      pipe_vld_d = '0;
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
         pipe_pc_d[i] = pipe_pc_q[i];
      end

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         pipe_vld_d[0] = issue;
         pipe_pc_d[0]  = fetch_pc_q;
         for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_pc_d[i]  = pipe_pc_q[i-1];
         end
         if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
         end
         if (enq_ok) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (deq) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({enq_ok, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         pipe_vld_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pipe_vld_q <= pipe_vld_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_pc_q[i] <= pipe_pc_d[i];
         end
      end
   end

   // Queue payload storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         q_inst_q[tail_q] <= imem_rdata;
         q_pc_q[tail_q]   <= pipe_pc_q[MEM_LATENCY-1];
      end
   end

   // The credit rule makes a write into a full queue unreachable.
   assert property (@(posedge clk) disable iff (reset)
      !(enq_ok && !deq && (count_q == CNT_W'(QUEUE_DEPTH))))
      else $error("fetch_unit: prefetch queue overflow");

endmodule
